// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched - butterfly scheduler for an in-place radix-2 DIT FFT.
//
// Issues N/2 butterfly commands per stage to a shared butterfly datapath and
// its twiddle ROM. It counts write-backs and starts the next stage only after
// every result of the current stage has been written.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle run request, honoured only while busy=0
//   busy, done       run in progress / one-cycle completion pulse
//   bf_valid/ready   command handshake towards the datapath
//   addr_a, addr_b   upper/lower leg data addresses (addr_b = addr_a + 2^stage)
//   tw_idx           twiddle index, W = exp(-j*2*pi*tw_idx/2^TW_W)
//   stage            current stage 0..LOG2N-1
//   bf_last          marks the final butterfly of a stage
//   wb_valid         one strobe per butterfly result written back
//   err              sticky unexpected write-back flag, cleared by start
module fft_bfly_sched #(
    parameter int LOG2N = 9,
    parameter int TW_W  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW_W-1:0]  tw_idx,
    output logic [3:0]       stage,
    output logic             bf_last,
    input  logic             wb_valid,
    output logic             err
);

    localparam int                HALF_N     = 1 << (LOG2N - 1);
    localparam logic [LOG2N-1:0]  HALF_CNT   = LOG2N'(HALF_N);
    localparam logic [LOG2N-1:0]  ADDR_ONE   = LOG2N'(1);
    localparam logic [LOG2N-2:0]  B_ONE      = (LOG2N-1)'(1);
    localparam logic [3:0]        LAST_STAGE = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [3:0]        stage_r, stage_n;
    logic [LOG2N-2:0]  b_r, b_n;
    logic [LOG2N-1:0]  wb_cnt_r, wb_cnt_n;
    logic              err_r, err_n;
    logic              busy_r, done_r, bf_valid_r;

    logic [LOG2N-1:0]  b_ext_s, half_s, pos_s, grp_s, addr_a_s;
    logic [3:0]        tw_sh_s;
    logic [TW_W-1:0]   tw_s;
    logic              bf_last_s;
    logic              counting_s, wb_full_s;
    logic [LOG2N-1:0]  wb_cnt_inc_s;

    // Command fields derived from the registered stage and butterfly counter.
    always_comb begin
        b_ext_s   = {1'b0, b_r};
        half_s    = ADDR_ONE << stage_r;
        pos_s     = b_ext_s & (half_s - ADDR_ONE);
        grp_s     = b_ext_s >> stage_r;
        addr_a_s  = (grp_s << (stage_r + 4'd1)) | pos_s;
        tw_sh_s   = LAST_STAGE - stage_r;
        // pos < 2^s, so pos << (LOG2N-1-s) always fits in LOG2N-1 bits.
        tw_s      = (TW_W'(pos_s) << tw_sh_s) << (TW_W - LOG2N);
        bf_last_s = &b_r;
    end

    // Write-back counter increment; the count saturates at N/2.
    always_comb begin
        counting_s   = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        wb_full_s    = (wb_cnt_r == HALF_CNT);
        wb_cnt_inc_s = wb_cnt_r + {{(LOG2N-1){1'b0}}, (wb_valid & ~wb_full_s)};
    end

    // Next-state logic for the stage sequencer.
    always_comb begin
        state_n  = state_r;
        stage_n  = stage_r;
        b_n      = b_r;
        wb_cnt_n = counting_s ? wb_cnt_inc_s : wb_cnt_r;
        // Write-back outside a stage, or beyond N/2 within one, is an error.
        err_n    = err_r | (wb_valid & (~counting_s | wb_full_s));
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    state_n  = ST_ISSUE;
                    stage_n  = 4'd0;
                    b_n      = {(LOG2N-1){1'b0}};
                    wb_cnt_n = {LOG2N{1'b0}};
                    err_n    = 1'b0;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bf_ready) begin
                    if (bf_last_s) begin
                        state_n = ST_DRAIN;
                    end else begin
                        b_n = b_r + B_ONE;
                    end
                end else begin
                    state_n = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (wb_cnt_inc_s == HALF_CNT) begin
                    if (stage_r < LAST_STAGE) begin
                        state_n  = ST_ISSUE;
                        stage_n  = stage_r + 4'd1;
                        b_n      = {(LOG2N-1){1'b0}};
                        wb_cnt_n = {LOG2N{1'b0}};
                    end else begin
                        state_n  = ST_FIN;
                    end
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            stage_r    <= 4'd0;
            b_r        <= {(LOG2N-1){1'b0}};
            wb_cnt_r   <= {LOG2N{1'b0}};
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bf_valid_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            stage_r    <= stage_n;
            b_r        <= b_n;
            wb_cnt_r   <= wb_cnt_n;
            err_r      <= err_n;
            busy_r     <= (state_n == ST_ISSUE) || (state_n == ST_DRAIN);
            done_r     <= (state_n == ST_FIN);
            bf_valid_r <= (state_n == ST_ISSUE);
        end
    end

    // Command fields read as zero whenever no command is offered.
    assign addr_a   = bf_valid_r ? addr_a_s : {LOG2N{1'b0}};
    assign addr_b   = bf_valid_r ? (addr_a_s + half_s) : {LOG2N{1'b0}};
    assign tw_idx   = bf_valid_r ? tw_s : {TW_W{1'b0}};
    assign bf_last  = bf_valid_r & bf_last_s;
    assign bf_valid = bf_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign stage    = stage_r;
    assign err      = err_r;

endmodule

// File: tb/tb_fft_bfly_sched.sv
module tb_fft_bfly_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LOG2N=3 instance
    logic       rst3_n, start3, busy3, done3, valid3, ready3, last3, wb3, err3;
    logic [2:0] addr_a3, addr_b3;
    logic [8:0] tw3;
    logic [3:0] stage3;
    // LOG2N=9 instance
    logic       rst9_n, start9, busy9, done9, valid9, ready9, last9, wb9, err9;
    logic [8:0] addr_a9, addr_b9;
    logic [8:0] tw9;
    logic [3:0] stage9;

    fft_bfly_sched #(.LOG2N(3), .TW_W(9)) dut3 (
        .clk(clk), .rst_n(rst3_n), .start(start3), .busy(busy3), .done(done3),
        .bf_valid(valid3), .bf_ready(ready3), .addr_a(addr_a3), .addr_b(addr_b3),
        .tw_idx(tw3), .stage(stage3), .bf_last(last3), .wb_valid(wb3), .err(err3)
    );

    fft_bfly_sched #(.LOG2N(9), .TW_W(9)) dut9 (
        .clk(clk), .rst_n(rst9_n), .start(start9), .busy(busy9), .done(done9),
        .bf_valid(valid9), .bf_ready(ready9), .addr_a(addr_a9), .addr_b(addr_b9),
        .tw_idx(tw9), .stage(stage9), .bf_last(last9), .wb_valid(wb9), .err(err9)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Hand-computed N=8 command sequence: stage0, stage1, stage2
    int exp_a [12];
    int exp_b [12];
    int exp_tw[12];

    int         acc3, done3_cnt, drop3, acc9, done9_cnt;
    logic       hold3, prev_wb3, rand3;
    logic [19:0] f3_prev;
    logic [3:0] pipe3, pipe9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample before the edge, drive after it.
    task automatic cyc();
        logic a3, a9;
        int idx3;
        logic [19:0] f3;
        a3   = valid3 && ready3;
        a9   = valid9 && ready9;
        idx3 = acc3;
        f3   = {stage3, addr_a3, addr_b3, tw3, last3};
        if (hold3) begin
            chk("stall_valid", 32'(valid3), 32'd1);
            chk("stall_fields", 32'(f3), 32'(f3_prev));
        end
        if (a3) begin
            if (idx3 < 12) begin
                chk("addr_a", 32'(addr_a3), exp_a[idx3]);
                chk("addr_b", 32'(addr_b3), exp_b[idx3]);
                chk("tw_idx", 32'(tw3), exp_tw[idx3]);
                chk("bf_last", 32'(last3), 32'((idx3 % 4) == 3));
            end else begin
                chk("accept_overflow", 32'(idx3), 32'd11);
            end
            acc3++;
        end
        if (done3) begin
            done3_cnt++;
            chk("done_busy", 32'(busy3), 32'd0);
            chk("done_after_wb", 32'(prev_wb3), 32'd1);
        end
        hold3    = valid3 && !ready3;
        f3_prev  = f3;
        prev_wb3 = wb3;
        if (a9) acc9++;
        if (done9) done9_cnt++;
        @(posedge clk);
        #1;
        pipe3  = {pipe3[2:0], a3 && (idx3 != drop3)};
        wb3    = pipe3[3];
        pipe9  = {pipe9[2:0], a9};
        wb9    = pipe9[3];
        start3 = 1'b0;
        start9 = 1'b0;
        if (rand3) ready3 = 1'($urandom_range(0, 1));
    endtask

    task automatic run3(input int maxc);
        int n;
        int d0;
        n  = 0;
        d0 = done3_cnt;
        while (done3_cnt == d0 && n < maxc) begin
            cyc();
            n++;
        end
        chk("run3_timeout", 32'(done3_cnt != d0), 32'd1);
    endtask

    task automatic new_run3();
        acc3 = 0; done3_cnt = 0; pipe3 = 4'd0; hold3 = 1'b0;
    endtask

    initial begin
        int n;
        int d;
        exp_a  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        exp_b  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        exp_tw = '{0, 0, 0, 0, 0, 128, 0, 128, 0, 64, 128, 192};
        rst3_n = 1'b0; rst9_n = 1'b0;
        start3 = 1'b0; start9 = 1'b0; ready3 = 1'b0; ready9 = 1'b1;
        wb3 = 1'b0; wb9 = 1'b0; rand3 = 1'b0; drop3 = -1;
        acc9 = 0; done9_cnt = 0; pipe9 = 4'd0; prev_wb3 = 1'b0; f3_prev = 20'd0;
        new_run3();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_flags", 32'({busy3, done3, valid3, last3, err3}), 32'd0);
        chk("rst_fields", 32'({addr_a3, addr_b3, tw3, stage3}), 32'd0);
        rst3_n = 1'b1; rst9_n = 1'b1;
        cyc();

        // T1/T2: ready held high, write-back 4 cycles after accept
        ready3 = 1'b1; new_run3();
        start3 = 1'b1;
        cyc();
        chk("t1_first_cmd", 32'({busy3, valid3}), 32'd3);
        run3(100);
        chk("t1_accepts", 32'(acc3), 32'd12);
        repeat (3) cyc();
        chk("t1_done_once", 32'(done3_cnt), 32'd1);
        chk("t1_idle", 32'({busy3, valid3, err3}), 32'd0);

        // T3: random bf_ready stalls
        new_run3(); rand3 = 1'b1;
        start3 = 1'b1;
        cyc();
        run3(400);
        rand3 = 1'b0; ready3 = 1'b1;
        chk("t3_accepts", 32'(acc3), 32'd12);
        chk("t3_done_once", 32'(done3_cnt), 32'd1);

        // T4: withhold the last write-back of stage 0
        new_run3(); drop3 = 3;
        start3 = 1'b1;
        cyc();
        n = 0;
        while (acc3 < 4 && n < 40) begin
            cyc();
            n++;
        end
        repeat (8) cyc();
        chk("t4_drain", 32'({valid3, busy3, stage3}), 32'({1'b0, 1'b1, 4'd0}));
        chk("t4_no_done", 32'(done3_cnt), 32'd0);
        wb3 = 1'b1;
        cyc();
        chk("t4_next_stage", 32'({valid3, stage3}), 32'({1'b1, 4'd1}));
        drop3 = -1;
        run3(100);
        chk("t4_accepts", 32'(acc3), 32'd12);

        // T5: start while busy, stray write-back in IDLE
        new_run3();
        start3 = 1'b1;
        cyc();
        repeat (3) cyc();
        start3 = 1'b1;
        cyc();
        run3(100);
        chk("t5_accepts", 32'(acc3), 32'd12);
        chk("t5_err_clean", 32'(err3), 32'd0);
        repeat (2) cyc();
        wb3 = 1'b1;
        cyc();
        chk("t5_err_set", 32'({err3, busy3}), 32'({1'b1, 1'b0}));
        new_run3();
        start3 = 1'b1;
        cyc();
        chk("t5_err_cleared", 32'({err3, busy3}), 32'({1'b0, 1'b1}));
        run3(100);
        chk("t5_rerun_accepts", 32'(acc3), 32'd12);

        // T6: reset mid stage 1 on the N=512 instance, then a full run
        acc9 = 0; done9_cnt = 0; pipe9 = 4'd0;
        start9 = 1'b1;
        cyc();
        n = 0;
        while (!(stage9 == 4'd1 && acc9 >= 276) && n < 2000) begin
            cyc();
            n++;
        end
        chk("t6_stage1", 32'(stage9), 32'd1);
        #1;
        rst9_n = 1'b0;
        #1;
        chk("t6_async_rst", 32'({busy9, done9, valid9, last9, err9, addr_a9, addr_b9, tw9, stage9}), 32'd0);
        pipe9 = 4'd0; wb9 = 1'b0;
        d = done9_cnt;
        repeat (3) cyc();
        pipe9 = 4'd0; wb9 = 1'b0;
        rst9_n = 1'b1;
        cyc();
        chk("t6_no_done", 32'(done9_cnt), 32'(d));
        acc9 = 0; done9_cnt = 0;
        start9 = 1'b1;
        cyc();
        n = 0;
        while (done9_cnt == 0 && n < 5000) begin
            cyc();
            n++;
        end
        chk("t6_accepts", 32'(acc9), 32'd2304);
        chk("t6_done_once", 32'(done9_cnt), 32'd1);
        chk("t6_err", 32'({err9, busy9}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
